// File: rtl/stream_map_addk.sv
// stream_map_addk: elastic per-lane add/sub map over a valid/ready stream.
// Optional STREAM_MAP_SAT_EN: saturating arithmetic plus a sat_flag output.
module stream_map_addk #(
    parameter int WIDTH  = 8,
    parameter int LANES  = 1,
    parameter int STAGES = 2,
    parameter int K      = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             mode,
    input  logic [WIDTH-1:0]       addend,
    input  logic [WIDTH*LANES-1:0] sIn,
    input  logic                   sIn_valid,
    output logic                   sIn_ready,
    output logic [WIDTH*LANES-1:0] sOut,
    output logic                   sOut_valid,
    input  logic                   sOut_ready,
`ifdef STREAM_MAP_SAT_EN
    output logic                   sat_flag,
`endif
    output logic [15:0]            count
);

    localparam logic [WIDTH-1:0] KW = WIDTH'(K);

    logic [WIDTH*LANES-1:0] r_data [STAGES];
    logic [STAGES-1:0]      r_vld;
    logic                   r_init;
    logic [15:0]            r_count;
    logic [STAGES-1:0]      w_load;
    logic [WIDTH*LANES-1:0] w_res;
    logic                   w_acc;
`ifdef STREAM_MAP_SAT_EN
    logic [STAGES-1:0]      r_sat;
    logic                   w_clip;
`endif

    always_comb begin
        logic [WIDTH:0]   v_ext;
        logic [WIDTH-1:0] v_op;
        logic [WIDTH-1:0] v_lane;
        w_res = '0;
`ifdef STREAM_MAP_SAT_EN
        w_clip = 1'b0;
`endif
        for (int i = 0; i < LANES; i++) begin
            v_ext  = '0;
            v_op   = (mode == 2'd0) ? KW : addend;
            v_lane = sIn[i*WIDTH +: WIDTH];
            case (mode)
                2'd0, 2'd1: v_ext = {1'b0, v_lane} + {1'b0, v_op};
                2'd2:       v_ext = {1'b0, v_lane} - {1'b0, v_op};
                default:    v_ext = {1'b0, v_lane};
            endcase
            v_lane = v_ext[WIDTH-1:0];
`ifdef STREAM_MAP_SAT_EN
            // bit WIDTH is carry for add, borrow for sub
            if (v_ext[WIDTH]) begin
                v_lane = (mode == 2'd2) ? '0 : '1;
                w_clip = 1'b1;
            end
`endif
            w_res[i*WIDTH +: WIDTH] = v_lane;
        end
    end

    // a stage may load when empty or when its beat leaves this cycle
    always_comb begin
        logic v_go;
        v_go = sOut_ready;
        for (int j = STAGES - 1; j >= 0; j--) begin
            v_go      = !r_vld[j] || v_go;
            w_load[j] = v_go;
        end
    end

    assign sIn_ready  = r_init && w_load[0];
    assign w_acc      = sIn_valid && sIn_ready;
    assign sOut       = r_data[STAGES-1];
    assign sOut_valid = r_vld[STAGES-1];
    assign count      = r_count;
`ifdef STREAM_MAP_SAT_EN
    assign sat_flag   = r_sat[STAGES-1];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld   <= '0;
            r_init  <= 1'b0;
            r_count <= '0;
            for (int j = 0; j < STAGES; j++) begin
                r_data[j] <= '0;
            end
`ifdef STREAM_MAP_SAT_EN
            r_sat   <= '0;
`endif
        end else begin
            r_init <= 1'b1;
            if (sOut_valid && sOut_ready) begin
                r_count <= r_count + 16'd1;
            end
            if (w_load[0]) begin
                r_vld[0] <= w_acc;
                if (w_acc) begin
                    r_data[0] <= w_res;
`ifdef STREAM_MAP_SAT_EN
                    r_sat[0]  <= w_clip;
`endif
                end
            end
            for (int j = 1; j < STAGES; j++) begin
                if (w_load[j]) begin
                    r_vld[j] <= r_vld[j-1];
                    if (r_vld[j-1]) begin
                        r_data[j] <= r_data[j-1];
`ifdef STREAM_MAP_SAT_EN
                        r_sat[j]  <= r_sat[j-1];
`endif
                    end
                end
            end
        end
    end

endmodule
